// File: rtl/cs_pkg.sv
// Shared encodings for the simple computer: FSM states, opcodes, ALU selects
// and address-mux selects, used by the control unit, the datapath and the top.
package cs_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_MEMRD  = 3'd3;
    localparam logic [2:0] ST_MEMWR  = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_MEMRD  = ST_MEMRD,
        S_MEMWR  = ST_MEMWR,
        S_HALT   = ST_HALT
    } state_e;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_JZ    = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd8;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_IR = 1'b1;

    // LOAD (and anything that is not an ALU op) passes memory data through.
    function automatic logic [1:0] aluFor(input logic [3:0] op);
        case (op)
            OP_ADD:  aluFor = ALU_ADD;
            OP_SUB:  aluFor = ALU_SUB;
            OP_AND:  aluFor = ALU_AND;
            default: aluFor = ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/cs_control_unit_if.sv
// Control-unit <-> datapath/memory bundle; the master side is the sequencer.
interface cs_control_unit_if #(
    parameter int OPW  = 4,
    parameter int CNTW = 16
);
    logic            start;
    logic [OPW-1:0]  opcode;
    logic            acc_zero;
    logic            mem_ready;
    logic            addr_sel;
    logic            mem_rd;
    logic            mem_wr;
    logic            ir_load;
    logic            pc_inc;
    logic            pc_load;
    logic            pc_clr;
    logic            acc_load;
    logic [1:0]      alu_op;
    logic            busy;
    logic            halted;
    logic            illegal;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  start, opcode, acc_zero, mem_ready,
        output addr_sel, mem_rd, mem_wr, ir_load, pc_inc, pc_load, pc_clr,
               acc_load, alu_op, busy, halted, illegal, instr_count
    );

    modport slave (
        output start, opcode, acc_zero, mem_ready,
        input  addr_sel, mem_rd, mem_wr, ir_load, pc_inc, pc_load, pc_clr,
               acc_load, alu_op, busy, halted, illegal, instr_count
    );
endinterface

// File: rtl/cs_control_unit.sv
// Fetch/decode/execute sequencer: registered state, sticky illegal flag and
// retired-instruction counter; all strobes decoded combinationally from state.
module cs_control_unit
    import cs_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    cs_control_unit_if.master  bus
);

    localparam int CW = $bits(bus.instr_count);

    state_e          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic [CW-1:0]   count_q;
    logic            retire;
    logic [3:0]      op;

    assign op = 4'(bus.opcode);

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        retire       = 1'b0;
        bus.addr_sel = ADDR_PC;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.pc_load  = 1'b0;
        bus.pc_clr   = 1'b0;
        bus.acc_load = 1'b0;
        bus.alu_op   = ALU_PASS;
        bus.halted   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by reset so a start held during reset produces no strobe.
                if (bus.start) begin
                    bus.pc_clr = reset;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_load = 1'b1;
                    bus.pc_inc  = 1'b1;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND: state_d = S_MEMRD;
                    OP_STORE: state_d = S_MEMWR;
                    OP_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        bus.pc_load = (op == OP_JMP) || (op == OP_JZ && bus.acc_zero);
                        illegal_d   = illegal_q || (op > OP_HALT);
                        state_d     = S_FETCH;
                        retire      = 1'b1;
                    end
                endcase
            end
            S_MEMRD: begin
                bus.addr_sel = ADDR_IR;
                bus.mem_rd   = 1'b1;
                bus.alu_op   = aluFor(op);
                if (bus.mem_ready) begin
                    bus.acc_load = 1'b1;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_MEMWR: begin
                bus.addr_sel = ADDR_IR;
                bus.mem_wr   = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                bus.halted = 1'b1;
                if (bus.start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = count_q;

    // Counter wraps naturally; illegal stays set across the wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (retire) count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_cs_control_unit.sv
// Bench for cs_control_unit: a small PC/IR/ACC/memory model runs programs,
// and scoreboard queues hold the stores, ALU selects and halt states expected.
module tb_cs_control_unit;

    logic        clk;
    logic        reset;
    logic [15:0] mem [256];
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [15:0] acc;
    logic [7:0]  memAddr;
    logic [15:0] memData;

    logic [23:0] storeQ [$];
    logic [23:0] haltQ  [$];
    logic [1:0]  aluQ   [$];

    int checkCount = 0;
    int errorCount = 0;
    int accLoadSeen = 0;
    int pcLoadSeen = 0;
    logic haltedPrev = 1'b0;

    cs_control_unit_if #(.OPW(4), .CNTW(16)) bus ();

    cs_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign memAddr      = bus.addr_sel ? ir[7:0] : pc;
    assign memData      = mem[memAddr];
    assign bus.opcode   = ir[15:12];
    assign bus.acc_zero = (acc == 16'h0000);

    // Datapath model: reacts to the strobes exactly as the real datapath would.
    always @(posedge clk) begin
        if (!reset) begin
            pc  <= 8'h00;
            ir  <= 16'h0000;
            acc <= 16'h0000;
        end else begin
            if (bus.pc_clr)       pc <= 8'h00;
            else if (bus.pc_load) pc <= ir[7:0];
            else if (bus.pc_inc)  pc <= pc + 8'h01;
            if (bus.ir_load) ir <= memData;
            if (bus.acc_load) begin
                case (bus.alu_op)
                    2'b00:   acc <= memData;
                    2'b01:   acc <= acc + memData;
                    2'b10:   acc <= acc - memData;
                    default: acc <= acc & memData;
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare DUT-produced events against queued expectations.
    always @(negedge clk) begin
        #1;
        if (bus.mem_wr) begin
            checkOutput("wr_no_rd", 32'(bus.mem_rd), 32'd0);
            checkOutput("wr_addr_sel", 32'(bus.addr_sel), 32'd1);
        end
        if (bus.mem_wr && bus.mem_ready) begin
            if (storeQ.size() == 0) checkOutput("store_unexpected", 32'd1, 32'd0);
            else checkOutput("store", {8'h00, memAddr, acc}, {8'h00, storeQ.pop_front()});
        end
        if (bus.acc_load) begin
            accLoadSeen <= accLoadSeen + 1;
            if (aluQ.size() == 0) checkOutput("acc_load_unexpected", 32'd1, 32'd0);
            else checkOutput("alu_op", 32'(bus.alu_op), 32'(aluQ.pop_front()));
        end
        if (bus.pc_load) pcLoadSeen <= pcLoadSeen + 1;
        if (bus.halted && !haltedPrev) begin
            if (haltQ.size() == 0) checkOutput("halt_unexpected", 32'd1, 32'd0);
            else checkOutput("halt_count_pc", {8'h00, bus.instr_count, pc}, {8'h00, haltQ.pop_front()});
        end
        haltedPrev <= bus.halted;
    end

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    // One-cycle start pulse; pc_clr is checked in the start cycle itself.
    task automatic applyStimulus(input string tag, input logic expPcClr);
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        checkOutput(tag, 32'(bus.pc_clr), 32'(expPcClr));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns the cycle index (start cycle = 0) at which halted is first seen.
    task automatic waitHalt(input string tag, output int cycles);
        cycles = 1;
        while (!bus.halted && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, 32'(bus.halted), 32'd1);
    endtask

    initial begin
        int cyc;
        int rdCycles;
        int irLoads;
        int pcIncs;
        int snap;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        clearMem();
        resetDut();
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_halted", 32'(bus.halted), 32'd0);
        checkOutput("rst_illegal", 32'(bus.illegal), 32'd0);
        checkOutput("rst_count", 32'(bus.instr_count), 32'd0);
        checkOutput("rst_strobes", {27'd0, bus.mem_rd, bus.mem_wr, bus.pc_clr, bus.ir_load, bus.acc_load}, 32'd0);

        // NOP, HALT: start cycle + 2 + 2 cycles before halted shows.
        mem[0] = 16'h0000;
        mem[1] = 16'h8000;
        haltQ.push_back({16'd2, 8'd2});
        applyStimulus("start_pc_clr", 1'b1);
        checkOutput("fetch_busy", 32'(bus.busy), 32'd1);
        waitHalt("halt_nop", cyc);
        checkOutput("lat_nop_halt", 32'(cyc), 32'd5);

        // Resume from HALT at PC=2: LOAD, ADD, STORE, HALT.
        mem[2]    = 16'h1010;
        mem[3]    = 16'h3011;
        mem[4]    = 16'h2012;
        mem[5]    = 16'h8000;
        mem[8'h10] = 16'h1234;
        mem[8'h11] = 16'h0101;
        storeQ.push_back({8'h12, 16'h1335});
        aluQ.push_back(2'b00);
        aluQ.push_back(2'b01);
        haltQ.push_back({16'd6, 8'd6});
        snap = accLoadSeen;
        applyStimulus("resume_pc_clr", 1'b0);
        waitHalt("halt_alu", cyc);
        checkOutput("lat_alu_prog", 32'(cyc), 32'd12);
        checkOutput("acc_loads", 32'(accLoadSeen - snap), 32'd2);

        // Three wait states in FETCH.
        resetDut();
        clearMem();
        mem[0] = 16'h8000;
        haltQ.push_back({16'd1, 8'd1});
        bus.mem_ready = 1'b0;
        applyStimulus("ws_pc_clr", 1'b1);
        rdCycles = 0;
        irLoads  = 0;
        pcIncs   = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_ready = 1'b1;
            #1;
            rdCycles += int'(bus.mem_rd);
            irLoads  += int'(bus.ir_load);
            pcIncs   += int'(bus.pc_inc);
            if (i == 3) checkOutput("ws_ir_load_ready", 32'(bus.ir_load), 32'd1);
            @(negedge clk);
        end
        #1;
        checkOutput("ws_rd_cycles", 32'(rdCycles), 32'd4);
        checkOutput("ws_ir_loads", 32'(irLoads), 32'd1);
        checkOutput("ws_pc_incs", 32'(pcIncs), 32'd1);
        checkOutput("ws_decode_no_rd", 32'(bus.mem_rd), 32'd0);
        waitHalt("halt_ws", cyc);

        // JZ taken (ACC=0), LOAD 7, JZ not taken, HALT at 7.
        resetDut();
        clearMem();
        mem[0]     = 16'h7005;
        mem[5]     = 16'h1020;
        mem[6]     = 16'h7009;
        mem[7]     = 16'h8000;
        mem[9]     = 16'h8000;
        mem[8'h20] = 16'h0007;
        aluQ.push_back(2'b00);
        haltQ.push_back({16'd4, 8'd8});
        snap = pcLoadSeen;
        applyStimulus("jz_pc_clr", 1'b1);
        waitHalt("halt_jz", cyc);
        checkOutput("lat_jz_prog", 32'(cyc), 32'd10);
        checkOutput("jz_pc_loads", 32'(pcLoadSeen - snap), 32'd1);

        // Undefined opcode sets a sticky flag.
        resetDut();
        clearMem();
        mem[0] = 16'hC000;
        mem[1] = 16'h0000;
        mem[2] = 16'h8000;
        mem[3] = 16'h0000;
        mem[4] = 16'h8000;
        haltQ.push_back({16'd3, 8'd3});
        applyStimulus("ill_pc_clr", 1'b1);
        waitHalt("halt_ill", cyc);
        checkOutput("illegal_set", 32'(bus.illegal), 32'd1);
        haltQ.push_back({16'd5, 8'd5});
        applyStimulus("ill_resume_pc_clr", 1'b0);
        waitHalt("halt_ill2", cyc);
        checkOutput("illegal_sticky", 32'(bus.illegal), 32'd1);
        resetDut();
        checkOutput("illegal_cleared", 32'(bus.illegal), 32'd0);

        // Reset while a STORE waits for memory; start held during reset.
        clearMem();
        mem[0] = 16'h2030;
        applyStimulus("wr_pc_clr", 1'b1);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("memwr_wait", 32'(bus.mem_wr), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("memwr_hold", 32'(bus.mem_wr), 32'd1);
        reset     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rstwr_mem_wr", 32'(bus.mem_wr), 32'd0);
        checkOutput("rstwr_busy", 32'(bus.busy), 32'd0);
        checkOutput("rstwr_count", 32'(bus.instr_count), 32'd0);
        checkOutput("rstwr_pc_clr", 32'(bus.pc_clr), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rstwr_start_ignored", 32'(bus.busy), 32'd0);
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("idle_after_rst", {30'd0, bus.busy, bus.halted}, 32'd0);

        checkOutput("storeQ_empty", 32'(storeQ.size()), 32'd0);
        checkOutput("aluQ_empty", 32'(aluQ.size()), 32'd0);
        checkOutput("haltQ_empty", 32'(haltQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
